// File: rtl/afifo_pattern_pkg.sv
// Shared definitions for the async-FIFO pattern producer.
// Covers mode encodings, FSM states and the LFSR tap table.
package afifo_pattern_pkg;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK1 = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  typedef enum logic [2:0] {
    ST_DELAY,
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

  // Maximal-length feedback masks: tap n of the polynomial maps to bit n-1.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] t;
    case (width)
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/afifo_pattern_gen.sv
// Pattern word generator: holds the current word, reloads on run start and
// steps one position per advance pulse using the mode captured at load.
module afifo_pattern_gen
  import afifo_pattern_pkg::*;
#(
  parameter int          W    = 12,
  parameter int unsigned SEED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic         advance,
  output logic [W-1:0] word
);

  localparam logic [W-1:0] SEED_W     = W'(SEED);
  localparam logic [W-1:0] TAPS       = W'(lfsr_taps(W));
  localparam logic [W-1:0] LFSR_START = (SEED_W == '0) ? W'(1) : SEED_W;

  logic [1:0]   mode_q;
  logic [W-1:0] start_word;

  always_comb begin
    start_word = SEED_W;
    case (mode)
      MODE_INC:   start_word = SEED_W;
      MODE_LFSR:  start_word = LFSR_START;
      MODE_WALK1: start_word = W'(1);
      MODE_ALT:   start_word = SEED_W;
      default:    start_word = SEED_W;
    endcase
  end

  // The LFSR is seeded nonzero, so the XOR feedback can never reach zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_INC;
      word   <= '0;
    end else if (load) begin
      mode_q <= mode;
      word   <= start_word;
    end else if (advance) begin
      case (mode_q)
        MODE_INC:   word <= word + 1'b1;
        MODE_LFSR:  word <= {word[W-2:0], ^(word & TAPS)};
        MODE_WALK1: word <= {word[W-2:0], word[W-1]};
        MODE_ALT:   word <= ~word;
        default:    word <= word;
      endcase
    end
  end

endmodule

// File: rtl/afifo_pattern_producer.sv
// Async-FIFO stimulus source: start-up delay, write-clock divider and the
// run/gap/done sequencer that drives the FIFO write port on wclk falls.
module afifo_pattern_producer
  import afifo_pattern_pkg::*;
#(
  parameter int          W           = 12,
  parameter int          DIV_BITS    = 14,
  parameter int unsigned START_DELAY = 2**26-1,
  parameter int unsigned SEED        = 1,
  parameter int unsigned COUNT       = 0,
  parameter int unsigned BURST_LEN   = 0,
  parameter int unsigned GAP_PERIODS = 4,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             wfull,
  output logic             wclk,
  output logic             w,
  output logic [W-1:0]     wd,
  output logic             done,
  output logic [CNT_W-1:0] words
);

  localparam int DLY_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int BURST_W = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
  localparam int GAP_W   = (GAP_PERIODS > 1) ? $clog2(GAP_PERIODS) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST =
    (START_DELAY == 0) ? '0 : DLY_W'(START_DELAY - 1);

  state_t               state;
  logic [DLY_W-1:0]     dly_cnt;
  logic [DIV_BITS-1:0]  div_cnt;
  logic [BURST_W-1:0]   burst_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [W-1:0]         pat_word;
  logic                 fall;
  logic                 count_hit;
  logic                 burst_hit;
  logic                 gen_load;
  logic                 gen_advance;

  assign wclk        = div_cnt[DIV_BITS-1];
  assign fall        = (state != ST_DELAY) && (&div_cnt);
  assign count_hit   = (COUNT != 0) && (words == CNT_W'(COUNT));
  assign burst_hit   = (BURST_LEN != 0) && (burst_cnt == BURST_W'(BURST_LEN));
  assign gen_load    = fall && (state == ST_IDLE) && en;
  assign gen_advance = fall && (state == ST_RUN) && en && !count_hit &&
                       !burst_hit && !wfull;

  afifo_pattern_gen #(
    .W    (W),
    .SEED (SEED)
  ) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .mode    (mode),
    .advance (gen_advance),
    .word    (pat_word)
  );

  // Everything except the divider only moves on the edge that drops wclk,
  // keeping wd stable for half a period around each wclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DELAY;
      dly_cnt   <= '0;
      div_cnt   <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      w         <= 1'b0;
      wd        <= '0;
      done      <= 1'b0;
      words     <= '0;
    end else begin
      if (state != ST_DELAY)
        div_cnt <= div_cnt + 1'b1;
      case (state)
        ST_DELAY: begin
          if (dly_cnt == DLY_LAST)
            state <= ST_IDLE;
          else
            dly_cnt <= dly_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (fall) begin
            w <= 1'b0;
            if (en) begin
              words     <= '0;
              done      <= 1'b0;
              burst_cnt <= '0;
              state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (fall) begin
            if (!en) begin
              w     <= 1'b0;
              state <= ST_IDLE;
            end else if (count_hit) begin
              w     <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (burst_hit) begin
              // The idle period on this fall already counts as the first gap period.
              w <= 1'b0;
              if (GAP_PERIODS > 1) begin
                gap_cnt <= GAP_W'(GAP_PERIODS - 1);
                state   <= ST_GAP;
              end else begin
                burst_cnt <= '0;
              end
            end else if (wfull) begin
              w <= 1'b0;
            end else begin
              w         <= 1'b1;
              wd        <= pat_word;
              words     <= words + 1'b1;
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (fall) begin
            w <= 1'b0;
            if (!en) begin
              state <= ST_IDLE;
            end else if (gap_cnt <= GAP_W'(1)) begin
              burst_cnt <= '0;
              state     <= ST_RUN;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (fall) begin
            w <= 1'b0;
            if (!en)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/afifo_pattern_producer.md
Name: afifo_pattern_producer

Overview:
- Parametrised stimulus source for async-FIFO bring-up on iCE40 boards. Runs from the board's PLL clock and generates a divided write clock `wclk`. Drives `w`/`wd` into the FIFO write port.
- Successor to the fixed 12-bit incrementing producer. Adds:
  - selectable data patterns;
  - `wfull` backpressure;
  - burst/gap shaping;
  - a finite word count with a `done` flag;
  - run gating through `en`.

Parameters:
- `W`, 12: data width, legal range 8..32.
- `DIV_BITS`, 14: divider width. The `wclk` period is 2^`DIV_BITS` `clk` cycles, 50% duty. Minimum value is 1.
- `START_DELAY`, 2^26-1: number of `clk` cycles after reset before the divider starts.
- `SEED`, 1: first word of the INC, LFSR and ALT patterns.
- `COUNT`, 0: words per run. 0 means unlimited.
- `BURST_LEN`, 0: words per burst. 0 means continuous.
- `GAP_PERIODS`, 4: idle `wclk` periods between bursts.
- `CNT_W`, 32: width of the `words` counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  run enable, level-sensitive.
- `mode`  in  2  pattern select: 0=INC, 1=LFSR, 2=WALK1, 3=ALT. Latched at run start.
- `wfull`  in  1  FIFO full flag, `wclk` domain.
- `wclk`  out  1  generated write clock, registered.
- `w`  out  1  write strobe, registered.
- `wd`  out  `W`  write data, registered.
- `done`  out  1  set when `COUNT` words have been written in this run.
- `words`  out  `CNT_W`  number of words written in the current run.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - outputs: `wclk`, `w`, `wd`, `done`, `words` all = 0;
  - internal state: delay counter, divider and burst/gap counters = 0; state = DELAY.
- States:
  - DELAY: count `clk` cycles; `wclk` held at 0. After `START_DELAY` cycles, go to IDLE. The divider then runs freely and is never gated again.
  - `wclk`: `wclk` = divider MSB. RISE = the edge where the divider goes 2^(`DIV_BITS`-1)-1 -> 2^(`DIV_BITS`-1). FALL = the edge where it wraps all-ones -> 0.
  - Decision point: all `w`/`wd`/count updates happen only on the `clk` edge that produces FALL. `wd` is therefore stable for half a period either side of each `wclk` rise.
  - IDLE: `w`=0. On a FALL with `en`=1:
    - latch `mode`;
    - load the pattern generator with its start word;
    - clear `words`, `done` and the burst counter;
    - go to RUN.
    - No word is presented on this FALL.
  - RUN, at each FALL, priority order:
    1. `en`=0: `w`<=0, go to IDLE (`words`/`done` hold).
    2. `COUNT`!=0 and `words`==`COUNT`: `w`<=0, `done`<=1, go to DONE.
    3. `BURST_LEN`!=0 and the burst counter == `BURST_LEN`: `w`<=0, load the gap counter, go to GAP.
    4. `wfull`=1: `w`<=0, `wd` holds, the pattern does not advance.
    5. Otherwise: `w`<=1, `wd`<=current pattern word; advance the pattern; `words`+1 (wraps mod 2^`CNT_W`); burst counter +1.
  - Acceptance: `wfull` only changes on a `wclk` rise, so the value sampled at FALL holds through the next rise. Every `w`=1 rise is therefore an accepted write; no retry path exists.
  - GAP: `w`=0 for `GAP_PERIODS` FALLs, then return to RUN with the burst counter cleared. `en`=0 during GAP goes to IDLE.
  - DONE: `w`=0, `done`=1 until `en`=0, then go to IDLE (`done` stays high until the next run start).
- Patterns, all mod 2^`W`:
  - INC: `SEED`, `SEED`+1, ...
  - LFSR: maximal-length Fibonacci, taps per `W`; a seed of 0 is forced to 1; never yields 0.
  - WALK1: 1, 2, 4, ..., 2^(`W`-1), 1, ...
  - ALT: `SEED`, ~`SEED`, `SEED`, ...
- `mode` changes during RUN are ignored until the next run start.

Decomposition:
- Package `afifo_pattern_pkg`:
  - mode encoding constants;
  - LFSR tap table as a function of `W` (8..32);
  - state encoding.
- Sub-module `afifo_pattern_gen`:
  - ports: `W`, `SEED`, `clk`, `rst_n`, `load`, `mode`, `advance`, `word`;
  - one-cycle registered `advance`;
  - `word` valid while idle.
- The top level owns the delay, divider, FSM, counters and output registers.

Test Plan:
(All scenarios use `W`=12, `DIV_BITS`=2, `START_DELAY`=8, `COUNT`=0, `BURST_LEN`=0 unless stated otherwise.)
- Reset/delay: release `rst_n`, `en`=1 -> `wclk` stays 0 for 8 `clk` cycles, then toggles every 2 cycles. The first FALL only starts the run. `wd`=0x001,0x002,0x003 at successive rises with `w`=1. Assert `rst_n` mid-run -> all outputs 0 immediately.
- Backpressure: INC; hold `wfull`=1 for 3 `wclk` periods after word 0x004 -> `w`=0 for exactly 3 rises, `wd` holds 0x004. The next word is 0x005; no gap or duplicate appears in the rise-sampled sequence.
- Count/done: `COUNT`=5 -> exactly 5 rises with `w`=1 (0x001..0x005), then `done`=1 and `words`=5. Drop and re-raise `en` -> `done` clears and the sequence restarts at 0x001.
- Burst/gap: `BURST_LEN`=3, `GAP_PERIODS`=2 -> pattern of 3 writes, 2 idle periods, repeating; data continues across gaps (0x004 follows the gap).
- Patterns:
  - WALK1 -> 0x001, 0x002, ..., 0x800, 0x001.
  - ALT with `SEED`=0x5A5 -> 0x5A5, 0xA5A alternating.
  - LFSR -> 4095 distinct nonzero words, then repeats the first.
- Mode latch: change `mode` INC->WALK1 mid-run -> no effect until `en` toggles low/high.
